fx2_slave_fifo_model: RTL and testbench

- Synthesizable model of the Cypress FX2 slave-FIFO side of the USB link, i.e. the responder to the FPGA's FX2 master interface. Responds to fx2_slcs_n/slrd_n/slwr_n/sloe_n/pktend_n/fx2_a, drives the FX2 flags and the shared 16-bit bus.
- Contains EP2 (host->FPGA, OUT) and EP6 (FPGA->host, IN) FIFOs.
- Host-side valid/ready ports stand in for the USB host. Used in the FFT system bench and in loopback FPGA builds.

---
 rtl/fx2_slave_fifo_model_if.sv | 43 ++++
 rtl/fx2_slave_fifo_model.sv | 228 ++++++++++++++++++++++
 tb/tb_fx2_slave_fifo_model.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fx2_slave_fifo_model_if.sv
// FX2 slave-FIFO strobes/flags plus the host-side EP2/EP6 streams.
// No latency of its own. The data bus stays a plain inout on the model, so the tristate net is resolved outside the interface.
// Backpressure: host_din_ready and host_dout_valid carry the flow control.
interface fx2_slave_fifo_model_if;
    logic        fx2_slcs_n;
    logic        fx2_slwr_n;
    logic        fx2_slrd_n;
    logic        fx2_sloe_n;
    logic        fx2_pktend_n;
    logic [1:0]  fx2_a;
    logic        fx2_flaga;
    logic        fx2_flagb;
    logic        fx2_flagc;
    logic        fx2_flagd;
    logic        host_din_valid;
    logic        host_din_ready;
    logic [15:0] host_din;
    logic        host_dout_valid;
    logic        host_dout_ready;
    logic [15:0] host_dout;
    logic        host_dout_last;
    logic [3:0]  err_status;

    modport slave (
        input  fx2_slcs_n, fx2_slwr_n, fx2_slrd_n, fx2_sloe_n, fx2_pktend_n, fx2_a,
        output fx2_flaga, fx2_flagb, fx2_flagc, fx2_flagd,
        input  host_din_valid, host_din,
        output host_din_ready,
        output host_dout_valid, host_dout, host_dout_last,
        input  host_dout_ready,
        output err_status
    );

    modport master (
        output fx2_slcs_n, fx2_slwr_n, fx2_slrd_n, fx2_sloe_n, fx2_pktend_n, fx2_a,
        input  fx2_flaga, fx2_flagb, fx2_flagc, fx2_flagd, err_status
    );

    modport host (
        output host_din_valid, host_din, host_dout_ready,
        input  host_din_ready, host_dout_valid, host_dout, host_dout_last
    );
endinterface

// File: rtl/fx2_slave_fifo_model.sv
// FX2 slave-FIFO model: EP2 (host->FPGA) and EP6 (FPGA->host) FIFOs behind the FX2 strobe interface.
// Latency: FWFT heads, flags follow post-edge counts; FX2_FLAG_LATENCY_EN adds one flag register stage.
// Backpressure: host side is valid/ready; FX2 side is flag-based, and bad strobes raise sticky err_status.

module fx2_ep_fifo #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_dat,
    input  logic                  push_tag,
    input  logic                  tag_tail,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head_dat,
    output logic                  head_tag,
    output logic [DEPTH_LOG2:0]   count,
    output logic [DEPTH_LOG2:0]   count_nxt,
    output logic                  full,
    output logic                  empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH-1:0]      tag;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    assign full     = (count == CNT_FULL);
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign head_dat = mem[rd_ptr];
    assign head_tag = tag[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (push_ok && !pop_ok) begin
            count_nxt = count + CNT_ONE;
        end else if (!push_ok && pop_ok) begin
            count_nxt = count - CNT_ONE;
        end
    end

    // Storage is deliberately not reset; validity comes from the pointers/count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            tag    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr      <= wr_ptr + PTR_ONE;
                tag[wr_ptr] <= push_tag;
            end else if (tag_tail) begin
                tag[wr_ptr - PTR_ONE] <= 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count <= count_nxt;
        end
    end
endmodule

module fx2_slave_fifo_model #(
    parameter int         DEPTH_LOG2 = 9,
    parameter logic [1:0] EP2_ADDR   = 2'b00,
    parameter logic [1:0] EP6_ADDR   = 2'b10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    fx2_slave_fifo_model_if.slave  fx2,
    inout  wire [15:0]             fx2_db
);
    localparam logic [DEPTH_LOG2:0] CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0] CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    // flag vector order {d, c, b, a}; reset = EP2 empty, EP6 empty
    localparam logic [3:0]          FLAG_RST = 4'b1010;

    logic                  sel;
    logic                  ep2_sel;
    logic                  ep6_sel;
    logic                  rd_stb;
    logic                  wr_stb;
    logic                  pktend_stb;
    logic                  bus_oe;
    logic [15:0]           bus_dat;

    logic [15:0]           ep2_head;
    logic                  ep2_tag_unused;
    logic [DEPTH_LOG2:0]   ep2_count_unused;
    logic [DEPTH_LOG2:0]   ep2_count_nxt;
    logic                  ep2_full;
    logic                  ep2_empty;

    logic [15:0]           ep6_head;
    logic                  ep6_head_last;
    logic [DEPTH_LOG2:0]   ep6_count;
    logic [DEPTH_LOG2:0]   ep6_count_nxt;
    logic                  ep6_full;
    logic                  ep6_empty;

    logic                  wr_ok;
    logic                  host_pop;
    logic                  tail_live;
    logic                  tag_tail;
    logic [3:0]            err_set;
    logic [3:0]            err_q;
    logic [3:0]            flag_nxt;
    logic [3:0]            flag_q;
    logic [3:0]            flag_out;

    assign sel        = !fx2.fx2_slcs_n;
    assign ep2_sel    = sel && (fx2.fx2_a == EP2_ADDR);
    assign ep6_sel    = sel && (fx2.fx2_a == EP6_ADDR);
    assign rd_stb     = ep2_sel && !fx2.fx2_slrd_n;
    assign wr_stb     = ep6_sel && !fx2.fx2_slwr_n;
    assign pktend_stb = ep6_sel && !fx2.fx2_pktend_n;

    assign bus_oe  = ep2_sel && !fx2.fx2_sloe_n;
    assign bus_dat = ep2_empty ? 16'h0000 : ep2_head;
    assign fx2_db  = bus_oe ? bus_dat : 16'hzzzz;

    fx2_ep_fifo #(.WIDTH(16), .DEPTH_LOG2(DEPTH_LOG2)) u_ep2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fx2.host_din_valid),
        .push_dat  (fx2.host_din),
        .push_tag  (1'b0),
        .tag_tail  (1'b0),
        .pop       (rd_stb),
        .head_dat  (ep2_head),
        .head_tag  (ep2_tag_unused),
        .count     (ep2_count_unused),
        .count_nxt (ep2_count_nxt),
        .full      (ep2_full),
        .empty     (ep2_empty)
    );

    // The write captures the resolved bus, so a contending master still lands a word.
    fx2_ep_fifo #(.WIDTH(16), .DEPTH_LOG2(DEPTH_LOG2)) u_ep6 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (wr_stb),
        .push_dat  (fx2_db),
        .push_tag  (pktend_stb),
        .tag_tail  (tag_tail),
        .pop       (fx2.host_dout_ready),
        .head_dat  (ep6_head),
        .head_tag  (ep6_head_last),
        .count     (ep6_count),
        .count_nxt (ep6_count_nxt),
        .full      (ep6_full),
        .empty     (ep6_empty)
    );

    assign wr_ok     = wr_stb && !ep6_full;
    assign host_pop  = fx2.host_dout_ready && !ep6_empty;
    // A lone pktend needs the newest word to survive this edge.
    assign tail_live = !ep6_empty && !(host_pop && (ep6_count == CNT_ONE));
    assign tag_tail  = pktend_stb && !wr_ok && tail_live;

    assign err_set[0] = rd_stb && ep2_empty;
    assign err_set[1] = wr_stb && ep6_full;
    assign err_set[2] = sel && !fx2.fx2_sloe_n && !fx2.fx2_slwr_n;
    assign err_set[3] = pktend_stb && !wr_ok && !tail_live;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 4'h0;
        end else begin
            err_q <= err_q | err_set;
        end
    end

    assign flag_nxt[0] = (ep2_count_nxt != '0);
    assign flag_nxt[1] = (ep6_count_nxt != CNT_FULL);
    assign flag_nxt[2] = (ep2_count_nxt == CNT_FULL);
    assign flag_nxt[3] = (ep6_count_nxt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q <= FLAG_RST;
        end else begin
            flag_q <= flag_nxt;
        end
    end

`ifdef FX2_FLAG_LATENCY_EN
    logic [3:0] flag_dly;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_dly <= FLAG_RST;
        end else begin
            flag_dly <= flag_q;
        end
    end

    assign flag_out = flag_dly;
`else
    assign flag_out = flag_q;
`endif

    assign fx2.fx2_flaga       = flag_out[0];
    assign fx2.fx2_flagb       = flag_out[1];
    assign fx2.fx2_flagc       = flag_out[2];
    assign fx2.fx2_flagd       = flag_out[3];
    assign fx2.host_din_ready  = !ep2_full;
    assign fx2.host_dout_valid = !ep6_empty;
    assign fx2.host_dout       = ep6_head;
    assign fx2.host_dout_last  = ep6_head_last;
    assign fx2.err_status      = err_q;
endmodule

// File: tb/tb_fx2_slave_fifo_model.sv
// Directed bench for fx2_slave_fifo_model with EP2/EP6 scoreboard queues.
// Flag timing expectations follow FX2_FLAG_LATENCY_EN when it is defined for the build.
module tb_fx2_slave_fifo_model;
`ifdef FX2_FLAG_LATENCY_EN
    localparam logic LAT = 1'b1;
`else
    localparam logic LAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tb_oe;
    logic [15:0] tb_dat;
    wire  [15:0] fx2_db;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] ep2_q[$];
    logic [16:0] ep6_q[$];
    logic [16:0] exp6;

    fx2_slave_fifo_model_if fx2 ();

    assign fx2_db = tb_oe ? tb_dat : 16'hzzzz;

    fx2_slave_fifo_model #(.DEPTH_LOG2(9), .EP2_ADDR(2'b00), .EP6_ADDR(2'b10)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .fx2    (fx2),
        .fx2_db (fx2_db)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic drain6(input int n);
        for (int k = 0; k < n; k++) begin
            to_neg();
            check("ep6_valid", 32'(fx2.host_dout_valid), 32'h1);
            exp6 = ep6_q.pop_front();
            check("ep6_word", 32'({fx2.host_dout_last, fx2.host_dout}), 32'(exp6));
            step();
        end
    endtask

    initial begin
        rst_n = 1'b0; tb_oe = 1'b0; tb_dat = 16'h0;
        fx2.fx2_slcs_n = 1'b1; fx2.fx2_slwr_n = 1'b1; fx2.fx2_slrd_n = 1'b1;
        fx2.fx2_sloe_n = 1'b1; fx2.fx2_pktend_n = 1'b1; fx2.fx2_a = 2'b00;
        fx2.host_din_valid = 1'b0; fx2.host_din = 16'h0; fx2.host_dout_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state; the model must leave the bus to the master.
        tb_oe = 1'b1; tb_dat = 16'h5A5A;
        to_neg();
        check("rst_flaga", 32'(fx2.fx2_flaga), 32'h0);
        check("rst_flagb", 32'(fx2.fx2_flagb), 32'h1);
        check("rst_flagc", 32'(fx2.fx2_flagc), 32'h0);
        check("rst_flagd", 32'(fx2.fx2_flagd), 32'h1);
        check("rst_err", 32'(fx2.err_status), 32'h0);
        check("rst_din_ready", 32'(fx2.host_din_ready), 32'h1);
        check("rst_dout_valid", 32'(fx2.host_dout_valid), 32'h0);
        check("rst_bus_z", 32'(fx2_db), 32'h5A5A);
        step();
        tb_oe = 1'b0;

        // EP2 read: host fills 8 words, master streams them out.
        for (int i = 0; i < 8; i++) begin
            fx2.host_din_valid = 1'b1;
            fx2.host_din = 16'(i + 1);
            ep2_q.push_back(16'(i + 1));
            step();
        end
        fx2.host_din_valid = 1'b0;
        to_neg();
        check("ep2_filled_flaga", 32'(fx2.fx2_flaga), 32'h1);
        step();
        fx2.fx2_slcs_n = 1'b0; fx2.fx2_a = 2'b00; fx2.fx2_sloe_n = 1'b0; fx2.fx2_slrd_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            to_neg();
            check("ep2_bus", 32'(fx2_db), 32'(ep2_q.pop_front()));
            if (i == 7) check("ep2_flaga_before_last", 32'(fx2.fx2_flaga), 32'h1);
            step();
        end
        fx2.fx2_slrd_n = 1'b1;
        to_neg();
        check("ep2_flaga_after_last", 32'(fx2.fx2_flaga), 32'(LAT));
        check("ep2_bus_empty_zero", 32'(fx2_db), 32'h0);
        check("ep2_err", 32'(fx2.err_status), 32'h0);
        step();
        to_neg();
        check("ep2_flaga_settled", 32'(fx2.fx2_flaga), 32'h0);
        step();

        // EP2 underflow: strobe on empty, then prove the read pointer did not move.
        fx2.fx2_slrd_n = 1'b0;
        step();
        fx2.fx2_slrd_n = 1'b1;
        to_neg();
        check("underflow_err", 32'(fx2.err_status), 32'h1);
        step();
        fx2.host_din_valid = 1'b1; fx2.host_din = 16'h00AB;
        ep2_q.push_back(16'h00AB);
        step();
        fx2.host_din_valid = 1'b0;
        to_neg();
        check("underflow_ptr", 32'(fx2_db), 32'(ep2_q.pop_front()));
        step();
        fx2.fx2_slrd_n = 1'b0;
        step();
        fx2.fx2_slrd_n = 1'b1; fx2.fx2_sloe_n = 1'b1; fx2.fx2_slcs_n = 1'b1;
        to_neg();
        check("underflow_err_kept", 32'(fx2.err_status), 32'h1);
        step();

        // EP6 write of 8 words, pktend on the last.
        fx2.fx2_slcs_n = 1'b0; fx2.fx2_a = 2'b10; tb_oe = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tb_dat = 16'h1000 + 16'(i);
            fx2.fx2_slwr_n = 1'b0;
            fx2.fx2_pktend_n = (i == 7) ? 1'b0 : 1'b1;
            ep6_q.push_back({(i == 7), tb_dat});
            to_neg();
            if (i == 1) check("ep6_flagd_first_edge", 32'(fx2.fx2_flagd), 32'(LAT));
            if (i == 2) check("ep6_flagd_second_edge", 32'(fx2.fx2_flagd), 32'h0);
            step();
        end
        fx2.fx2_slwr_n = 1'b1; fx2.fx2_pktend_n = 1'b1; tb_oe = 1'b0; fx2.fx2_slcs_n = 1'b1;
        to_neg();
        check("ep6_dout_valid", 32'(fx2.host_dout_valid), 32'h1);
        check("ep6_flagb", 32'(fx2.fx2_flagb), 32'h1);
        step();
        fx2.host_dout_ready = 1'b1;
        drain6(8);
        fx2.host_dout_ready = 1'b0;
        to_neg();
        check("ep6_drained_valid", 32'(fx2.host_dout_valid), 32'h0);
        check("ep6_drained_flagd", 32'(fx2.fx2_flagd), 32'(!LAT));
        step();
        to_neg();
        check("ep6_flagd_settled", 32'(fx2.fx2_flagd), 32'h1);
        check("ep6_err", 32'(fx2.err_status), 32'h1);
        step();

        // Lone pktend: dropped when empty, marks the newest word otherwise.
        fx2.fx2_slcs_n = 1'b0; fx2.fx2_a = 2'b10; fx2.fx2_pktend_n = 1'b0;
        step();
        fx2.fx2_pktend_n = 1'b1;
        to_neg();
        check("pktend_empty_err", 32'(fx2.err_status), 32'h9);
        step();
        tb_oe = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tb_dat = 16'h2000 + 16'(i);
            fx2.fx2_slwr_n = 1'b0;
            ep6_q.push_back({1'b0, tb_dat});
            step();
        end
        fx2.fx2_slwr_n = 1'b1; tb_oe = 1'b0; fx2.fx2_pktend_n = 1'b0;
        step();
        fx2.fx2_pktend_n = 1'b1; fx2.fx2_slcs_n = 1'b1;
        ep6_q[ep6_q.size() - 1][16] = 1'b1;
        to_neg();
        check("pktend_alone_err", 32'(fx2.err_status), 32'h9);
        step();
        fx2.host_dout_ready = 1'b1;
        drain6(2);
        fx2.host_dout_ready = 1'b0;

        // Strobes at an unmapped address are ignored without error.
        fx2.fx2_slcs_n = 1'b0; fx2.fx2_a = 2'b01; fx2.fx2_slwr_n = 1'b0; fx2.fx2_slrd_n = 1'b0;
        tb_oe = 1'b1; tb_dat = 16'h7777;
        step();
        fx2.fx2_slwr_n = 1'b1; fx2.fx2_slrd_n = 1'b1; tb_oe = 1'b0; fx2.fx2_slcs_n = 1'b1;
        to_neg();
        check("ignored_no_push", 32'(fx2.host_dout_valid), 32'h0);
        check("ignored_err", 32'(fx2.err_status), 32'h9);
        step();

        // Contention: output enable and write strobe together.
        fx2.fx2_slcs_n = 1'b0; fx2.fx2_a = 2'b00; fx2.fx2_sloe_n = 1'b0; fx2.fx2_slwr_n = 1'b0;
        step();
        fx2.fx2_slwr_n = 1'b1; fx2.fx2_sloe_n = 1'b1; fx2.fx2_slcs_n = 1'b1;
        to_neg();
        check("contention_err", 32'(fx2.err_status), 32'hD);
        check("contention_no_push", 32'(fx2.host_dout_valid), 32'h0);
        step();

        // EP6 full: 513 writes without drain, the last one dropped.
        fx2.fx2_slcs_n = 1'b0; fx2.fx2_a = 2'b10; tb_oe = 1'b1;
        for (int i = 0; i < 513; i++) begin
            tb_dat = 16'(i);
            fx2.fx2_slwr_n = 1'b0;
            if (i < 512) ep6_q.push_back({1'b0, tb_dat});
            to_neg();
            if (i == 511) check("full_flagb_before", 32'(fx2.fx2_flagb), 32'h1);
            if (i == 512) check("full_flagb_at_512", 32'(fx2.fx2_flagb), 32'(LAT));
            step();
        end
        fx2.fx2_slwr_n = 1'b1;
        to_neg();
        check("full_flagb", 32'(fx2.fx2_flagb), 32'h0);
        check("full_overflow_err", 32'(fx2.err_status), 32'hF);
        step();
        // Host pop and master write together at full: pop wins, write is dropped.
        tb_dat = 16'hBEEF; fx2.fx2_slwr_n = 1'b0; fx2.host_dout_ready = 1'b1;
        to_neg();
        exp6 = ep6_q.pop_front();
        check("full_simul_pop", 32'({fx2.host_dout_last, fx2.host_dout}), 32'(exp6));
        step();
        fx2.fx2_slwr_n = 1'b1; tb_oe = 1'b0; fx2.fx2_slcs_n = 1'b1;
        drain6(511);
        fx2.host_dout_ready = 1'b0;
        to_neg();
        check("full_drained_valid", 32'(fx2.host_dout_valid), 32'h0);
        step();
        to_neg();
        check("full_drained_flagd", 32'(fx2.fx2_flagd), 32'h1);
        check("full_drained_flagb", 32'(fx2.fx2_flagb), 32'h1);
        step();

        // Asynchronous reset in the middle of an EP6 burst.
        fx2.fx2_slcs_n = 1'b0; fx2.fx2_a = 2'b10; tb_oe = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tb_dat = 16'h3000 + 16'(i);
            fx2.fx2_slwr_n = 1'b0;
            step();
        end
        check("arst_pre_valid", 32'(fx2.host_dout_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        check("arst_flaga", 32'(fx2.fx2_flaga), 32'h0);
        check("arst_flagb", 32'(fx2.fx2_flagb), 32'h1);
        check("arst_flagc", 32'(fx2.fx2_flagc), 32'h0);
        check("arst_flagd", 32'(fx2.fx2_flagd), 32'h1);
        check("arst_dout_valid", 32'(fx2.host_dout_valid), 32'h0);
        check("arst_err", 32'(fx2.err_status), 32'h0);
        check("arst_din_ready", 32'(fx2.host_din_ready), 32'h1);
        fx2.fx2_slwr_n = 1'b1; tb_oe = 1'b0; fx2.fx2_slcs_n = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        to_neg();
        check("post_arst_flagd", 32'(fx2.fx2_flagd), 32'h1);
        check("post_arst_valid", 32'(fx2.host_dout_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
